// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 32-bit combinational ALU between the execute stage
// (port 0) and the address/branch-compare unit (port 1).
// Each port has a valid/ready request channel and a valid/ready response channel.
// The arbiter latches the granted operands, runs one ALU operation, and holds the
// registered result and flags until the granted requester accepts them.
// Optional build macro ALU_ARB_FIXED_PRIO_EN selects fixed priority: port 0 wins
// every collision and the pointer never moves. Without it, arbitration is round-robin.
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter bit RR_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req_valid0,
    output logic             o_req_ready0,
    input  logic [WIDTH-1:0] i_a0,
    input  logic [WIDTH-1:0] i_b0,
    input  logic [2:0]       i_ctrl0,
    input  logic             i_req_valid1,
    output logic             o_req_ready1,
    input  logic [WIDTH-1:0] i_a1,
    input  logic [WIDTH-1:0] i_b1,
    input  logic [2:0]       i_ctrl1,
    output logic             o_rsp_valid0,
    input  logic             i_rsp_ready0,
    output logic             o_rsp_valid1,
    input  logic             i_rsp_ready1,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_neg,
    output logic             o_negU,
    output logic             o_busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic             ptr;
    logic             gid;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [2:0]       op_ctrl;

    logic             grant_any;
    logic             grant_id;
    logic             prio;
    logic             rsp_take;

    logic [WIDTH-1:0] alu_y;
    logic             alu_zero;
    logic             alu_neg;
    logic             alu_negu;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign prio = 1'b0;
`else
    assign prio = ptr;
`endif

    // Grant selection in IDLE: the priority port wins a collision, otherwise the single requester wins.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (rst_n && state == IDLE) begin
            grant_any = i_req_valid0 | i_req_valid1;
            if (i_req_valid0 && i_req_valid1) begin
                grant_id = prio;
            end else begin
                grant_id = i_req_valid1;
            end
        end
    end

    assign o_req_ready0 = grant_any & ~grant_id;
    assign o_req_ready1 = grant_any & grant_id;

    assign o_rsp_valid0 = (state == DONE) & ~gid;
    assign o_rsp_valid1 = (state == DONE) & gid;
    assign rsp_take     = gid ? i_rsp_ready1 : i_rsp_ready0;
    assign o_busy       = (state != IDLE);

    // Shared ALU on the latched operands; neg/negU are the signed/unsigned a<b compare flags.
    always_comb begin
        alu_y = '0;
        case (op_ctrl)
            3'b000:  alu_y = op_a + op_b;
            3'b001:  alu_y = op_a - op_b;
            3'b010:  alu_y = op_a & op_b;
            3'b011:  alu_y = op_a | op_b;
            3'b100:  alu_y = op_a ^ op_b;
            3'b101:  alu_y = $signed(op_a) >>> op_b[4:0];
            3'b110:  alu_y = op_a >> op_b[4:0];
            default: alu_y = op_a << op_b[4:0];
        endcase
    end

    assign alu_zero = (alu_y == '0);
    assign alu_neg  = ($signed(op_a) < $signed(op_b));
    assign alu_negu = (op_a < op_b);

    // FSM, operand latches, pointer and registered result; reset discards any in-flight op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gid      <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_ctrl  <= '0;
            o_result <= '0;
            o_zero   <= 1'b0;
            o_neg    <= 1'b0;
            o_negU   <= 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
            ptr      <= 1'b0;
`else
            ptr      <= RR_INIT;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        gid     <= grant_id;
                        op_a    <= grant_id ? i_a1 : i_a0;
                        op_b    <= grant_id ? i_b1 : i_b0;
                        op_ctrl <= grant_id ? i_ctrl1 : i_ctrl0;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        ptr     <= ~grant_id;
`endif
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    o_result <= alu_y;
                    o_zero   <= alu_zero;
                    o_neg    <= alu_neg;
                    o_negU   <= alu_negu;
                    state    <= DONE;
                end
                DONE: begin
                    if (rsp_take) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with hand-computed
// expected results. Builds with or without ALU_ARB_FIXED_PRIO_EN; the collision
// scenario expects alternating grants by default and port-0-only grants when fixed.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_valid0, i_req_valid1;
    logic        o_req_ready0, o_req_ready1;
    logic [31:0] i_a0, i_b0, i_a1, i_b1;
    logic [2:0]  i_ctrl0, i_ctrl1;
    logic        o_rsp_valid0, o_rsp_valid1;
    logic        i_rsp_ready0, i_rsp_ready1;
    logic [31:0] o_result;
    logic        o_zero, o_neg, o_negU, o_busy;

    int checks   = 0;
    int failures = 0;

    alu_arbiter #(.WIDTH(32), .RR_INIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid0(i_req_valid0), .o_req_ready0(o_req_ready0),
        .i_a0(i_a0), .i_b0(i_b0), .i_ctrl0(i_ctrl0),
        .i_req_valid1(i_req_valid1), .o_req_ready1(o_req_ready1),
        .i_a1(i_a1), .i_b1(i_b1), .i_ctrl1(i_ctrl1),
        .o_rsp_valid0(o_rsp_valid0), .i_rsp_ready0(i_rsp_ready0),
        .o_rsp_valid1(o_rsp_valid1), .i_rsp_ready1(i_rsp_ready1),
        .o_result(o_result), .o_zero(o_zero), .o_neg(o_neg), .o_negU(o_negU),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_req_valid0 = 1'b1; i_req_valid1 = 1'b0;
        i_a0 = 32'd0; i_b0 = 32'd0; i_ctrl0 = 3'd0;
        i_a1 = 32'd0; i_b1 = 32'd0; i_ctrl1 = 3'd0;
        i_rsp_ready0 = 1'b0; i_rsp_ready1 = 1'b0;
        tick(); tick();
        checks++;
        if (o_req_ready0 !== 1'b0 || o_req_ready1 !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_ready got=%b%b want=00", o_req_ready0, o_req_ready1);
        end
        checks++;
        if (o_busy !== 1'b0 || o_rsp_valid0 !== 1'b0 || o_rsp_valid1 !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_ctrl got busy=%b rv=%b%b want 0/00", o_busy, o_rsp_valid0, o_rsp_valid1);
        end
        checks++;
        if (o_result !== 32'd0 || {o_zero, o_neg, o_negU} !== 3'b000) begin
            failures++; $display("[TB] FAIL reset_result got=%h flags=%b want=0/000", o_result, {o_zero, o_neg, o_negU});
        end
        i_req_valid0 = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        i_req_valid0 = 1'b1; i_a0 = 32'd2; i_b0 = 32'd2; i_ctrl0 = 3'b000;
        #1;
        checks++;
        if (o_req_ready0 !== 1'b1 || o_req_ready1 !== 1'b0) begin
            failures++; $display("[TB] FAIL add_ready got=%b%b want=10", o_req_ready0, o_req_ready1);
        end
        tick();
        i_req_valid0 = 1'b0; i_a0 = 32'hDEAD; i_b0 = 32'hBEEF; i_ctrl0 = 3'b100;
        checks++;
        if (o_busy !== 1'b1 || o_rsp_valid0 !== 1'b0) begin
            failures++; $display("[TB] FAIL add_busy got busy=%b rv0=%b want 1/0", o_busy, o_rsp_valid0);
        end
        tick();
        checks++;
        if (o_rsp_valid0 !== 1'b1 || o_rsp_valid1 !== 1'b0 || o_result !== 32'd4 || o_zero !== 1'b0) begin
            failures++; $display("[TB] FAIL add_rsp got rv=%b%b res=%0d z=%b want 10/4/0", o_rsp_valid0, o_rsp_valid1, o_result, o_zero);
        end
        i_rsp_ready0 = 1'b1;
        tick();
        i_rsp_ready0 = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_rsp_valid0 !== 1'b0) begin
            failures++; $display("[TB] FAIL add_idle got busy=%b rv0=%b want 0/0", o_busy, o_rsp_valid0);
        end
    endtask

    task automatic test_hold();
        i_req_valid1 = 1'b1; i_a1 = 32'd128; i_b1 = 32'd2; i_ctrl1 = 3'b001;
        #1;
        checks++;
        if (o_req_ready1 !== 1'b1 || o_req_ready0 !== 1'b0) begin
            failures++; $display("[TB] FAIL hold_ready got=%b%b want=01", o_req_ready0, o_req_ready1);
        end
        tick();
        i_req_valid1 = 1'b0; i_a1 = 32'd0;
        tick();
        i_rsp_ready0 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (o_rsp_valid1 !== 1'b1 || o_rsp_valid0 !== 1'b0 || o_result !== 32'd126 ||
                {o_zero, o_neg, o_negU} !== 3'b000) begin
                failures++; $display("[TB] FAIL hold_stable cyc=%0d got rv=%b%b res=%0d flags=%b want 01/126/000",
                                     k, o_rsp_valid0, o_rsp_valid1, o_result, {o_zero, o_neg, o_negU});
            end
            tick();
        end
        i_rsp_ready0 = 1'b0; i_rsp_ready1 = 1'b1;
        tick();
        i_rsp_ready1 = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_rsp_valid1 !== 1'b0) begin
            failures++; $display("[TB] FAIL hold_idle got busy=%b rv1=%b want 0/0", o_busy, o_rsp_valid1);
        end
    endtask

    task automatic test_collision();
        logic [2:0] exp_seq;
        logic       exp_port;
        logic       got_port;
        logic [31:0] exp_res;
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_seq = 3'b000;
`else
        exp_seq = 3'b010;
`endif
        i_req_valid0 = 1'b1; i_a0 = 32'd6;   i_b0 = 32'd10; i_ctrl0 = 3'b100;
        i_req_valid1 = 1'b1; i_a1 = 32'd127; i_b1 = 32'd2;  i_ctrl1 = 3'b010;
        i_rsp_ready0 = 1'b1; i_rsp_ready1 = 1'b1;
        for (int g = 0; g < 3; g++) begin
            exp_port = exp_seq[g];
            exp_res  = exp_port ? 32'd2 : 32'd12;
            #1;
            got_port = o_req_ready1;
            checks++;
            if ((o_req_ready0 ^ o_req_ready1) !== 1'b1 || got_port !== exp_port) begin
                failures++; $display("[TB] FAIL coll_grant%0d got ready=%b%b want port %0d", g, o_req_ready0, o_req_ready1, exp_port);
            end
            tick(); tick();
            checks++;
            if (o_rsp_valid0 !== ~exp_port || o_rsp_valid1 !== exp_port || o_result !== exp_res) begin
                failures++; $display("[TB] FAIL coll_rsp%0d got rv=%b%b res=%0d want port %0d res %0d",
                                     g, o_rsp_valid0, o_rsp_valid1, o_result, exp_port, exp_res);
            end
            tick();
        end
        i_req_valid0 = 1'b0;
        #1;
        checks++;
        if (o_req_ready1 !== 1'b1 || o_req_ready0 !== 1'b0) begin
            failures++; $display("[TB] FAIL coll_p1_ready got=%b%b want=01", o_req_ready0, o_req_ready1);
        end
        tick();
        i_req_valid1 = 1'b0;
        tick();
        checks++;
        if (o_rsp_valid1 !== 1'b1 || o_result !== 32'd2) begin
            failures++; $display("[TB] FAIL coll_p1_rsp got rv1=%b res=%0d want 1/2", o_rsp_valid1, o_result);
        end
        tick();
        i_rsp_ready0 = 1'b0; i_rsp_ready1 = 1'b0;
    endtask

    task automatic test_shift();
        logic [2:0]  ops [3]  = '{3'b101, 3'b110, 3'b111};
        logic [31:0] want [3] = '{32'hE0000003, 32'h20000003, 32'h0000003C};
        int          wait_cnt;
        for (int s = 0; s < 3; s++) begin
            i_req_valid0 = 1'b1; i_a0 = 32'h8000000F; i_b0 = 32'd2; i_ctrl0 = ops[s];
            tick();
            i_req_valid0 = 1'b0;
            wait_cnt = 0;
            while (o_rsp_valid0 !== 1'b1 && wait_cnt < 10) begin
                tick(); wait_cnt++;
            end
            checks++;
            if (o_rsp_valid0 !== 1'b1 || o_result !== want[s]) begin
                failures++; $display("[TB] FAIL shift%0d got rv0=%b res=%h want 1/%h", s, o_rsp_valid0, o_result, want[s]);
            end
            if (s == 0) begin
                checks++;
                if (o_neg !== 1'b1) begin
                    failures++; $display("[TB] FAIL sra_neg got=%b want=1", o_neg);
                end
            end
            i_rsp_ready0 = 1'b1;
            tick();
            i_rsp_ready0 = 1'b0;
        end
    endtask

    task automatic test_reset_busy();
        i_req_valid0 = 1'b1; i_a0 = 32'd128; i_b0 = 32'd2; i_ctrl0 = 3'b011;
        tick();
        i_req_valid0 = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (o_busy !== 1'b0 || o_result !== 32'd0) begin
            failures++; $display("[TB] FAIL rstbusy_state got busy=%b res=%0d want 0/0", o_busy, o_result);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (o_rsp_valid0 !== 1'b0 || o_rsp_valid1 !== 1'b0) begin
                failures++; $display("[TB] FAIL rstbusy_norsp cyc=%0d got rv=%b%b want 00", k, o_rsp_valid0, o_rsp_valid1);
            end
            tick();
        end
        i_req_valid0 = 1'b1; i_req_valid1 = 1'b1;
        i_a1 = 32'd1; i_b1 = 32'd1; i_ctrl1 = 3'b000;
        #1;
        checks++;
        if (o_req_ready0 !== 1'b1 || o_req_ready1 !== 1'b0) begin
            failures++; $display("[TB] FAIL rstbusy_ptr got ready=%b%b want 10", o_req_ready0, o_req_ready1);
        end
        tick();
        i_req_valid0 = 1'b0; i_req_valid1 = 1'b0;
        tick();
        checks++;
        if (o_rsp_valid0 !== 1'b1 || o_result !== 32'd130) begin
            failures++; $display("[TB] FAIL rstbusy_next got rv0=%b res=%0d want 1/130", o_rsp_valid0, o_result);
        end
        i_rsp_ready0 = 1'b1;
        tick();
        i_rsp_ready0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_hold();
        test_collision();
        test_shift();
        test_reset_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
